branch_predictor_bht: RTL and testbench

- PC-indexed branch history table (BHT) of 2-bit saturating counters.
- Produces the ID-stage taken/not-taken prediction consumed by the flush decision logic and the PC-select mux.
- Trained from the EX stage with the resolved outcome (the ALU zero flag for beq) and the prediction that travelled down the pipe with the branch.
- Also keeps branch and mispredict performance counters.

---
 rtl/bp_pkg.sv | 24 ++
 rtl/sat_counter2.sv | 22 ++
 rtl/branch_predictor_bht.sv | 75 +++++++
 tb/tb_branch_predictor_bht.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types, constants and saturating-step helper for the branch predictor
package bp_pkg;

    localparam int IDX_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_SNT = 2'b00,
        ST_WNT = 2'b01,
        ST_WT  = 2'b10,
        ST_ST  = 2'b11
    } ctr_state_t;

    function automatic logic [1:0] sat_step(input logic [1:0] cur, input logic up);
        logic [1:0] nxt;
        nxt = cur;
        if (up) begin
            if (cur != ST_ST) nxt = cur + 2'd1;
        end else begin
            if (cur != ST_SNT) nxt = cur - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - one 2-bit saturating counter with enable, direction and sync active-low reset
import bp_pkg::*;

module sat_counter2 #(
    parameter logic [1:0] INIT = ST_WT
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    input  logic       up,
    output logic [1:0] state
);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= INIT;
        end else if (en) begin
            state <= sat_step(state, up);
        end
    end

endmodule

// File: rtl/branch_predictor_bht.sv
// rtl/branch_predictor_bht.sv - PC-indexed 2-bit BHT with perf counters; BP_GSHARE_EN adds gshare indexing
import bp_pkg::*;

module branch_predictor_bht #(
    parameter int         IDX_W      = IDX_W_DEF,
    parameter logic [1:0] INIT_STATE = 2'b10,
    parameter int         CNT_W      = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      pc_i,
    input  logic             branch_i,
    output logic             predict_o,
    output logic [IDX_W-1:0] pred_idx_o,
    input  logic             upd_valid_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i,
    input  logic             upd_predict_i,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    localparam int DEPTH = 1 << IDX_W;

    logic [IDX_W-1:0] idx;
    logic [1:0]       table_q [DEPTH];
    logic             unused_pc;

    assign unused_pc = ^{pc_i[31:IDX_W+2], pc_i[1:0]};

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] ghr;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ghr <= '0;
        end else if (upd_valid_i) begin
            ghr <= {ghr[IDX_W-2:0], upd_taken_i};
        end
    end

    assign idx = pc_i[IDX_W+1:2] ^ ghr;
`else
    assign idx = pc_i[IDX_W+1:2];
`endif

    // Training always uses the index returned from EX, never a recomputed one.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        sat_counter2 #(
            .INIT (INIT_STATE)
        ) u_ctr (
            .clk   (clk_i),
            .rstn  (rst_i),
            .en    (upd_valid_i && (upd_idx_i == IDX_W'(i))),
            .up    (upd_taken_i),
            .state (table_q[i])
        );
    end

    // Read-before-write: a same-cycle update shows up only after the edge.
    assign predict_o  = branch_i & table_q[idx][1];
    assign pred_idx_o = idx;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            branch_cnt_o  <= '0;
            mispred_cnt_o <= '0;
        end else if (upd_valid_i) begin
            if (branch_cnt_o != '1) branch_cnt_o <= branch_cnt_o + CNT_W'(1);
            if ((upd_taken_i != upd_predict_i) && (mispred_cnt_o != '1))
                mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb/tb_branch_predictor_bht.sv - directed self-checking bench for branch_predictor_bht
module tb_branch_predictor_bht;

    localparam int IDX_W = 4;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_i;
    logic [31:0]      pc_i;
    logic             branch_i;
    logic             predict_o;
    logic [IDX_W-1:0] pred_idx_o;
    logic             upd_valid_i;
    logic [IDX_W-1:0] upd_idx_i;
    logic             upd_taken_i;
    logic             upd_predict_i;
    logic [CNT_W-1:0] branch_cnt_o;
    logic [CNT_W-1:0] mispred_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predictor_bht #(
        .IDX_W      (IDX_W),
        .INIT_STATE (2'b10),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .pc_i          (pc_i),
        .branch_i      (branch_i),
        .predict_o     (predict_o),
        .pred_idx_o    (pred_idx_o),
        .upd_valid_i   (upd_valid_i),
        .upd_idx_i     (upd_idx_i),
        .upd_taken_i   (upd_taken_i),
        .upd_predict_i (upd_predict_i),
        .branch_cnt_o  (branch_cnt_o),
        .mispred_cnt_o (mispred_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] pc);
        pc_i     = pc;
        branch_i = 1'b1;
        #1;
    endtask

    task automatic update(input logic [IDX_W-1:0] idx, input logic taken, input logic pred);
        upd_valid_i   = 1'b1;
        upd_idx_i     = idx;
        upd_taken_i   = taken;
        upd_predict_i = pred;
        tick();
        upd_valid_i   = 1'b0;
    endtask

    initial begin
        rst_i = 1'b0; pc_i = '0; branch_i = 1'b0;
        upd_valid_i = 1'b0; upd_idx_i = '0; upd_taken_i = 1'b0; upd_predict_i = 1'b0;
        tick(); tick();
        rst_i = 1'b1;

        lookup(32'h0000_0040);
        check("reset_predict", predict_o, 1);
        check("reset_idx", pred_idx_o, 0);
        check("reset_branch_cnt", branch_cnt_o, 0);
        check("reset_mispred_cnt", mispred_cnt_o, 0);
        branch_i = 1'b0; #1;
        check("no_branch_predict", predict_o, 0);
        check("no_branch_idx", pred_idx_o, 0);
        branch_i = 1'b1; #1;

        // idx 0: 10 -> 01 -> 00, both mispredicted
        update(4'd0, 1'b0, 1'b1);
        check("idx0_after_first_nt", predict_o, 0);
        update(4'd0, 1'b0, 1'b1);
        check("idx0_after_second_nt", predict_o, 0);
        check("idx0_branch_cnt", branch_cnt_o, 2);
        check("idx0_mispred_cnt", mispred_cnt_o, 2);

        // idx 3: five taken saturate at 11, then 11 -> 10 -> 01
        lookup(32'h0000_000C);
        check("idx3_pred_idx", pred_idx_o, 3);
        for (int k = 0; k < 5; k++) begin
            update(4'd3, 1'b1, 1'b1);
            check($sformatf("idx3_taken_%0d", k), predict_o, 1);
        end
        update(4'd3, 1'b0, 1'b1);
        check("idx3_after_sat_nt", predict_o, 1);
        update(4'd3, 1'b0, 1'b1);
        check("idx3_after_second_nt", predict_o, 0);
        check("idx3_branch_cnt", branch_cnt_o, 9);
        check("idx3_mispred_cnt", mispred_cnt_o, 4);

        // taken but predicted not-taken counts as a mispredict
        lookup(32'h0000_0014);
        update(4'd5, 1'b1, 1'b0);
        check("idx5_predict", predict_o, 1);
        check("idx5_branch_cnt", branch_cnt_o, 10);
        check("idx5_mispred_cnt", mispred_cnt_o, 5);
        // correct not-taken prediction: no mispredict
        update(4'd5, 1'b0, 1'b0);
        check("idx5_correct_branch_cnt", branch_cnt_o, 11);
        check("idx5_correct_mispred_cnt", mispred_cnt_o, 5);

        // same-index lookup and update: old value this cycle, new next
        lookup(32'h0000_001C);
        upd_valid_i = 1'b1; upd_idx_i = 4'd7; upd_taken_i = 1'b0; upd_predict_i = 1'b1;
        #1;
        check("same_idx_before_edge", predict_o, 1);
        tick();
        upd_valid_i = 1'b0;
        check("same_idx_after_edge", predict_o, 0);

        // upd_valid_i low: nothing changes
        upd_idx_i = 4'd7; upd_taken_i = 1'b1; upd_predict_i = 1'b0;
        tick(); tick();
        check("idle_predict", predict_o, 0);
        check("idle_branch_cnt", branch_cnt_o, 12);
        check("idle_mispred_cnt", mispred_cnt_o, 6);

        // reset wins over simultaneous update on idx 0 (currently 00)
        lookup(32'h0000_0040);
        check("pre_reset_idx0", predict_o, 0);
        rst_i = 1'b0;
        upd_valid_i = 1'b1; upd_idx_i = 4'd0; upd_taken_i = 1'b1; upd_predict_i = 1'b0;
        tick();
        rst_i = 1'b1; upd_valid_i = 1'b0; #1;
        check("reset_drop_idx0", predict_o, 1);
        check("reset_drop_branch_cnt", branch_cnt_o, 0);
        check("reset_drop_mispred_cnt", mispred_cnt_o, 0);
        lookup(32'h0000_001C);
        check("reset_restore_idx7", predict_o, 1);

`ifdef BP_GSHARE_EN
        for (int k = 0; k < 3; k++) update(4'd0, 1'b1, 1'b1);
        lookup(32'h0000_0000);
        check("gshare_idx", pred_idx_o, 7);
`else
        lookup(32'h0000_0000);
        check("pc_only_idx", pred_idx_o, 0);
        lookup(32'h0000_0043);
        check("pc_low_bits_ignored", pred_idx_o, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
